data_memory_sync: RTL and testbench

//  Clocked, parametrised data memory model for the CPU memory stage and testbenches.

---
 rtl/data_memory_sync_if.sv | 26 ++
 rtl/data_memory_sync.sv | 161 ++++++++++++++++
 tb/tb_data_memory_sync.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sync_if.sv
// Request/response bus between a memory-stage master and data_memory_sync.
// The master holds req_i and its qualifiers stable until it sees ack_o.
interface data_memory_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_i;
    logic                    we_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   data_i;
    logic [DATA_WIDTH/8-1:0] sel_i;
    logic                    ack_o;
    logic [DATA_WIDTH-1:0]   data_o;
    logic                    err_o;
    logic                    busy_o;

    modport master (
        output req_i, we_i, addr_i, data_i, sel_i,
        input  ack_o, data_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i, sel_i,
        output ack_o, data_o, err_o, busy_o
    );
endinterface

// File: rtl/data_memory_sync.sv
// Word-organised data memory with byte-lane writes, fixed wait-state latency,
// optional zero-fill sweep after reset, and an error response for out-of-range words.
module data_memory_sync #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 2048,
    parameter int WAIT_CYCLES  = 2,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    data_memory_sync_if.slave bus
);
    localparam int LANES   = DATA_WIDTH / 8;
    localparam int LANE_SH = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [IDX_W-1:0]        clr_idx;
    logic                    ack_q;
    logic                    err_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [LANES-1:0]        sel_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_sel
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < LANES; k++) begin
            if (lane_sel[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

    // With no wait states the response is formed on the accept edge, so the live
    // inputs stand in for the not-yet-latched request.
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_oor;
    logic [ADDR_WIDTH-1:0] q_idx;
    logic                  q_oor;
    logic                  enter_resp;

    always_comb begin
        cur_we   = we_q;
        cur_addr = addr_q;
        if (state == IDLE) begin
            cur_we   = bus.we_i;
            cur_addr = bus.addr_i;
        end
        cur_idx    = cur_addr >> LANE_SH;
        cur_oor    = cur_idx >= ADDR_WIDTH'(DEPTH);
        q_idx      = addr_q >> LANE_SH;
        q_oor      = q_idx >= ADDR_WIDTH'(DEPTH);
        enter_resp = ((state == IDLE) && bus.req_i && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd0));
    end

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = clr_idx;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if ((state == RESP) && we_q && !q_oor) begin
            mem_we    = 1'b1;
            mem_widx  = q_idx[IDX_W-1:0];
            mem_wdata = merge_lanes(mem[q_idx[IDX_W-1:0]], wdata_q, sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.req_i) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.data_i;
            sel_q   <= bus.sel_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR_ON_RST ? CLEAR : IDLE;
            busy_q   <= CLEAR_ON_RST;
            wait_cnt <= 4'd0;
            clr_idx  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.req_i) begin
                        busy_q <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 1'b1;
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // Response registers are loaded on the edge into RESP so ack and data appear together.
            if (enter_resp) begin
                ack_q <= 1'b1;
                if (cur_oor) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    err_q <= 1'b0;
                    if (!cur_we) rdata_q <= mem[cur_idx[IDX_W-1:0]];
                end
            end
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.err_o  = err_q;
    assign bus.data_o = rdata_q;
    assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: three instances (2, 0 and 15 wait states) driven
// through directed and random accesses and compared against an array model.
module tb_data_memory_sync;
    localparam int DEPTH = 2048;
    localparam int WC [3] = '{2, 0, 15};

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdat  [3];
    logic [3:0]  sel   [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];
    logic [31:0] dout  [3];

    logic [31:0] ref_mem [3][DEPTH];
    logic [31:0] last_do [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_memory_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req_i  = req[g];
        assign bus[g].we_i   = we[g];
        assign bus[g].addr_i = addr[g];
        assign bus[g].data_i = wdat[g];
        assign bus[g].sel_i  = sel[g];
        assign ack[g]  = bus[g].ack_o;
        assign err[g]  = bus[g].err_o;
        assign busy[g] = bus[g].busy_o;
        assign dout[g] = bus[g].data_o;

        data_memory_sync #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH),
            .WAIT_CYCLES(WC[g]), .CLEAR_ON_RST(g == 0)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; the model decides err/data from the word index and updates itself on writes.
    task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int exp_lat, input bit keep);
        int          n;
        logic [31:0] idx;
        logic [31:0] exp_d;
        logic        exp_e;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[k] && n < 64);
        chk($sformatf("ack_seen[%0d]", k), 32'(ack[k]), 32'd1);
        chk($sformatf("latency[%0d]", k), n, exp_lat);
        idx = a >> 2;
        if (idx >= DEPTH) begin
            exp_e = 1'b1;
            exp_d = '0;
        end else if (!w) begin
            exp_e = 1'b0;
            exp_d = ref_mem[k][idx];
        end else begin
            exp_e = 1'b0;
            exp_d = last_do[k];
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
        end
        last_do[k] = exp_d;
        chk($sformatf("err[%0d]@%h", k, a), 32'(err[k]), 32'(exp_e));
        chk($sformatf("data[%0d]@%h", k, a), dout[k], exp_d);
        if (!keep) begin
            req[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("ack_pulse[%0d]", k), 32'(ack[k]), 32'd0);
        end
    endtask

    initial begin
        int          n;
        bit          prev_keep;
        bit          kp;
        int          r;
        logic [31:0] a;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
            addr[k] = '0; wdat[k] = '0; sel[k] = '0; last_do[k] = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = '0;
        end
        #2;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", 32'(ack[k]), 32'd0);
            chk("rst_err", 32'(err[k]), 32'd0);
            chk("rst_data", dout[k], 32'd0);
            chk("rst_busy", 32'(busy[k]), (k == 0) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;

        // Zero-fill sweep on the clearing instance
        n = 0;
        while (busy[0] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("clear_cycles", n, 2048);
        access(0, 1'b0, 32'h1FFC, '0, 4'h0, 3, 1'b0);

        // Full write, partial-lane write, null write, out-of-range read
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 3, 1'b0);
        access(0, 1'b0, 32'h10, '0, 4'h0, 3, 1'b0);
        chk("t2_const", dout[0], 32'hDEADBEEF);
        access(0, 1'b1, 32'h10, 32'h00AB0000, 4'b0100, 3, 1'b0);
        access(0, 1'b0, 32'h10, '0, 4'h0, 3, 1'b0);
        chk("t3_const", dout[0], 32'hDEABBEEF);
        access(0, 1'b1, 32'h10, 32'h11223344, 4'b0000, 3, 1'b0);
        access(0, 1'b0, 32'h10, '0, 4'h0, 3, 1'b0);
        access(0, 1'b0, 32'h2000, '0, 4'h0, 3, 1'b0);
        chk("t4_err_const", 32'(err[0]), 32'd1);
        access(0, 1'b0, 32'h0, '0, 4'h0, 3, 1'b0);

        // Random mix, including aliases of word 0..3 just past the top and back-to-back runs
        prev_keep = 1'b0;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h2000 + 4 * $urandom_range(0, 3);
            else if (r == 1) a = $urandom;
            else             a = 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            kp = ($urandom_range(0, 2) == 0);
            access(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   prev_keep ? 4 : 3, kp);
            prev_keep = kp;
        end
        for (int w = 0; w < 4; w++)
            access(0, 1'b0, 32'(4 * w), '0, 4'h0, prev_keep && (w == 0) ? 4 : 3, 1'b0);

        // Back-to-back reads: zero wait states and fifteen wait states
        access(1, 1'b1, 32'h100, 32'h11111111, 4'hF, 1, 1'b0);
        access(1, 1'b1, 32'h104, 32'h22222222, 4'hF, 1, 1'b0);
        access(1, 1'b0, 32'h100, '0, 4'h0, 1, 1'b1);
        access(1, 1'b0, 32'h104, '0, 4'h0, 2, 1'b0);
        access(2, 1'b1, 32'h100, 32'hAAAA5555, 4'hF, 16, 1'b0);
        access(2, 1'b1, 32'h104, 32'h5A5AA5A5, 4'hF, 16, 1'b0);
        access(2, 1'b0, 32'h100, '0, 4'h0, 16, 1'b1);
        access(2, 1'b0, 32'h104, '0, 4'h0, 17, 1'b0);

        // Reset in the middle of a write's wait states leaves the word untouched
        access(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 16, 1'b0);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdat[2] = 32'h12345678; sel[2] = 4'hF;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(ack[2]);
        end
        rst[2] = 1'b0;
        req[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n += int'(ack[2]);
        end
        chk("abort_busy", 32'(busy[2]), 32'd0);
        chk("abort_data", dout[2], 32'd0);
        last_do[2] = '0;
        rst[2] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            n += int'(ack[2]);
        end
        chk("abort_no_ack", n, 0);
        access(2, 1'b0, 32'h20, '0, 4'h0, 16, 1'b0);
        chk("abort_const", dout[2], 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
